// File: rtl/prng_stream_checker.sv
// prng_stream_checker
// Receive-side checker for the xorshift32 generator. It tracks the seed
// handshake, regenerates the expected sequence locally and compares every
// received word in order. It reports pass/fail, the mismatch count, the index
// of the first bad word, an inter-word timeout and strobe-protocol violations.
// All logic runs on the rising edge of clk3, and every output is a flop.

module prng_stream_checker #(
  parameter int NUM_OUT = 256,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk3,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] seed,
  input  logic        out_valid,
  input  logic [31:0] rand_num,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_cnt,
  output logic [7:0]  first_err_idx,
  output logic        timeout,
  output logic        proto_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // The gap counter only has to count up to TIMEOUT.
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0]       LAST_IDX = 8'(NUM_OUT - 1);
  localparam logic [8:0]       ERR_MAX  = 9'(NUM_OUT);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);

  // One xorshift32 step. Each shift truncates to 32 bits.
  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [1:0]       state_r,   state_s;
  logic [31:0]      exp_r,     exp_s;
  logic [7:0]       idx_r,     idx_s;
  logic [GAP_W-1:0] gap_r,     gap_s;
  logic [8:0]       err_cnt_r, err_cnt_s;
  logic [7:0]       fidx_r,    fidx_s;
  logic             timeout_r, timeout_s;
  logic             proto_r,   proto_s;
  logic             pass_r,    pass_s;
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;

  // Next-state and next-output computation for the checker FSM.
  always_comb begin
    state_s   = state_r;
    exp_s     = exp_r;
    idx_s     = idx_r;
    gap_s     = gap_r;
    err_cnt_s = err_cnt_r;
    fidx_s    = fidx_r;
    timeout_s = timeout_r;
    proto_s   = proto_r;
    pass_s    = pass_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          exp_s     = xs_next(seed);
          idx_s     = 8'd0;
          gap_s     = '0;
          err_cnt_s = 9'd0;
          fidx_s    = 8'd0;
          timeout_s = 1'b0;
          proto_s   = 1'b0;
          pass_s    = 1'b0;
          state_s   = ST_CHECK;
        end else begin
          state_s   = ST_IDLE;
        end
        // A word with no check running is dropped. This also applies in
        // the seed cycle, because the seed's first word is due one edge later.
        if (out_valid) begin
          proto_s = 1'b1;
        end else begin
          proto_s = proto_s;
        end
      end

      ST_CHECK: begin
        // A re-seed while a check is running does not restart the check.
        if (in_valid) begin
          proto_s = 1'b1;
        end else begin
          proto_s = proto_r;
        end
        if (out_valid) begin
          if (rand_num != exp_r) begin
            if (err_cnt_r == 9'd0) begin
              fidx_s = idx_r;
            end else begin
              fidx_s = fidx_r;
            end
            if (err_cnt_r != ERR_MAX) begin
              err_cnt_s = err_cnt_r + 9'd1;
            end else begin
              err_cnt_s = err_cnt_r;
            end
          end else begin
            err_cnt_s = err_cnt_r;
          end
          // Advance from the local model, never from the received word, so
          // one bad word costs one error and does not cause more errors.
          exp_s = xs_next(exp_r);
          idx_s = idx_r + 8'd1;
          gap_s = '0;
          if (idx_r == LAST_IDX) begin
            state_s = ST_FIN;
            pass_s  = (err_cnt_s == 9'd0) && !timeout_r;
          end else begin
            state_s = ST_CHECK;
          end
        end else begin
          gap_s = gap_r + GAP_W'(1);
          if (gap_s == GAP_MAX) begin
            timeout_s = 1'b1;
            pass_s    = 1'b0;
            state_s   = ST_FIN;
          end else begin
            state_s   = ST_CHECK;
          end
        end
      end

      ST_FIN: begin
        if (in_valid || out_valid) begin
          proto_s = 1'b1;
        end else begin
          proto_s = proto_r;
        end
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // busy and done are derived from the next state, so as flops they
    // line up with the state they describe.
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_FIN);
  end

  // State and output registers. Reset aborts any check without a done pulse.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      exp_r     <= 32'd0;
      idx_r     <= 8'd0;
      gap_r     <= '0;
      err_cnt_r <= 9'd0;
      fidx_r    <= 8'd0;
      timeout_r <= 1'b0;
      proto_r   <= 1'b0;
      pass_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      exp_r     <= exp_s;
      idx_r     <= idx_s;
      gap_r     <= gap_s;
      err_cnt_r <= err_cnt_s;
      fidx_r    <= fidx_s;
      timeout_r <= timeout_s;
      proto_r   <= proto_s;
      pass_r    <= pass_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign err_cnt       = err_cnt_r;
  assign first_err_idx = fidx_r;
  assign timeout       = timeout_r;
  assign proto_err     = proto_r;

endmodule

// File: doc/prng_stream_checker.md
# prng_stream_checker

Receive-side companion to the `prng` block. It listens to the same seed handshake that starts the generator and independently regenerates the expected xorshift32 sequence. It then consumes the generator's `out_valid`/`rand_num` stream and compares each word in order. It reports pass/fail, an error count, the index of the first mismatch, a timeout, and protocol violations. It sits on the output-side clock (`clk3`) in both the bench harness and the on-chip self-test wrapper.

## Interface
- `NUM_OUT`, 256: words expected per seed.
- `TIMEOUT`, 1000: max `clk3` cycles allowed between seed and first word, and between consecutive words.
- `clk3`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  one-cycle seed strobe; already synchronous to `clk3`.
- `seed`  in  32  seed value, sampled when `in_valid`=1.
- `out_valid`  in  1  generator output strobe; need not be consecutive.
- `rand_num`  in  32  generator output word, sampled when `out_valid`=1.
- `busy`  out  1  high while a check is in progress.
- `done`  out  1  one-cycle pulse at the end of a check.
- `pass`  out  1  result of the last check; held until the next accepted seed.
- `err_cnt`  out  9  mismatch count, saturating at `NUM_OUT`.
- `first_err_idx`  out  8  index (0-based) of the first mismatching word; 0 if none.
- `timeout`  out  1  sticky: the last check ended by timeout.
- `proto_err`  out  1  sticky: the strobe protocol was violated.

## Operation
- Next-state function f(x), applied in order on 32-bit values with truncation:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
- Word k (k = 0…NUM_OUT-1) is expected to equal f^(k+1)(seed).
- FSM states are IDLE, CHECK and FIN.
- IDLE:
  - `in_valid`=1 loads `exp` ← f(seed) and clears `err_cnt`, `first_err_idx`, `idx`, the gap counter, `timeout`, `proto_err` and `pass`.
  - The FSM then goes to CHECK.
  - `out_valid`=1 in IDLE, including the same cycle as `in_valid`, sets `proto_err` and the word is discarded.
- CHECK:
  - Each `out_valid` compares `rand_num` against `exp`.
  - On mismatch: `err_cnt`++; if this is the first mismatch, `first_err_idx` ← `idx`.
  - After every compare: `exp` ← f(`exp`), `idx`++, and the gap counter clears.
  - The expected sequence always advances from the model, never from a received word.
  - When the word at `idx` = NUM_OUT-1 is accepted, the FSM goes to FIN.
  - `in_valid`=1 in CHECK sets `proto_err` and is otherwise ignored; there is no restart.
  - When the gap counter reaches TIMEOUT, `timeout` ← 1 and the FSM goes to FIN.
- FIN lasts one cycle:
  - `done`=1.
  - `pass` ← (`err_cnt`==0 && !`timeout`), using the final count.
  - The FSM then goes to IDLE.
  - `out_valid` in FIN sets `proto_err`.
  - `in_valid` in FIN is ignored and also sets `proto_err`.
- Seed 0 is legal: f(0)=0, so the expected sequence is all zeros.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`, `done`, `pass`, `timeout`, `proto_err` = 0.
  - `err_cnt` = 0, `first_err_idx` = 0.
  - `exp` = 0, `idx` = 0, gap counter = 0.
- Asserting reset mid-check aborts the check immediately; no `done` pulse is produced.
- `in_valid` at edge t gives `busy`=1 and a valid `exp` from t+1. The earliest accepted word is at t+1.
- The compare is combinational against `exp` in the `out_valid` cycle. Counters update on that edge.
- The last word accepted at edge n gives `done`=1 and updated `pass` during cycle n+1, and `busy`=0 from n+2.
  - `busy` is high in CHECK and FIN.
- Timeout fires on the edge where the gap count reaches TIMEOUT with no `out_valid`. `done` follows in the next cycle.
- All outputs are registered.

## Test plan
- Reset, then `in_valid` with seed=1, then 256 correct words (word0=0x00042021, word1=0x04080601) -> `done` 1 cycle after word255, `pass`=1, `err_cnt`=0, `proto_err`=0.
- Same stimulus, but word 5 is corrupted with its bit 0 flipped, and word 200 is also corrupted -> `pass`=0, `err_cnt`=2, `first_err_idx`=5.
- Seed=0x12345678; words arrive with random 0–50 cycle gaps, all correct -> `pass`=1. Then a second seed=0 with all-zero words -> `pass`=1.
- Seed=1; only 100 correct words, then silence -> `done` exactly TIMEOUT+1 cycles after word99, `timeout`=1, `pass`=0, `err_cnt`=0.
- `out_valid` while idle, and a second `in_valid` mid-check -> `proto_err`=1, the check continues, and the result matches the first seed.
- `rst_n` pulled low at word 128 -> all outputs are 0 immediately. A fresh seed afterwards then passes.
